lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Load/store unit between the execute stage and word-organised data memory. Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-aligned memory transactions with byte enables. Runs a req/ack handshake to a variable-latency memory. Returns sign/zero-extended load data, or an error code for misalignment, illegal funct3 or memory timeout.

Parameters:
DEPTH_BYTES, 1024, addressable data bytes; any address at or above this value is an access error
TIMEOUT, 16, max cycles mem_req stays high without mem_ack before the access is aborted (≥2)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  core request strobe
req_ready  out  1  unit can accept a request (high only in IDLE)
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3 of the load/store
req_addr  in  32  byte address from ALU
req_wdata  in  32  store data (rs2)
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  extended load data (0 for stores/errors)
rsp_err  out  2  00 ok, 01 misaligned, 10 timeout/out-of-range, 11 illegal funct3
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write
mem_be  out  4  byte lane enables, bit i = byte addr[1:0]==i
mem_addr  out  32  word address, byte address with [1:0]=00
mem_wdata  out  32  store data replicated into lanes
mem_ack  in  1  memory completes access this cycle
mem_rdata  in  32  read word, valid when mem_ack=1

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=00; mem_req=0; mem_we=0; mem_be=0; mem_addr=0; mem_wdata=0; timeout counter=0. Reset mid-transaction drops mem_req immediately with no response.
- States: IDLE, ACCESS, RESP.
- IDLE: handshake on req_valid&req_ready. Latch we, funct3, addr[1:0], wdata. Check in order: illegal funct3 (loads: 011,110,111; stores: anything but 000/001/010) -> err 11; misaligned (half with addr[0]=1, word with addr[1:0]!=00) -> err 01; addr ≥ DEPTH_BYTES -> err 10. On error go to RESP with no memory access. Otherwise drive mem_* registered and go to ACCESS; mem_req rises the cycle after acceptance.
- Byte enables: B -> 0001<<addr[1:0]; H -> 0011<<addr[1:0]; W -> 1111. Store data: SB replicates byte ×4, SH replicates half ×2, SW passes through. mem_be is also driven for loads, for information only.
- ACCESS: mem_req, mem_we, mem_be, mem_addr and mem_wdata stay stable until mem_ack. A mem_ack in the same cycle as the first mem_req is legal. On mem_ack: capture data and go to RESP, err 00. Counter increments each ACCESS cycle without ack. On reaching TIMEOUT: deassert mem_req, go to RESP, err 10, rdata 0. A late mem_ack outside ACCESS is ignored.
- Load extraction from captured mem_rdata, lane = addr[1:0]: LB/LBU take byte[lane], sign- or zero-extended; LH/LHU take half[lane[1]], sign- or zero-extended; LW takes the full word.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. A new request is accepted no earlier than the cycle after RESP. There is no backpressure on rsp; the core must stall on req_ready.
- Latency with zero-wait memory (ack on first mem_req cycle): accept at N, mem_req at N+1, rsp_valid at N+2. Error path: rsp_valid at N+1.
- mem_req is deasserted in the RESP and IDLE states.

Decomposition:
- Shared package lsu_pkg holds funct3 constants (F3_B/H/W/BU/HU), rsp_err codes (ERR_OK/MISALIGN/BUS/ILLEGAL) and state encodings.
- One natural sub-module: lsu_load_align, combinational (rdata word, funct3, lane -> extended data), reusable for a future cache.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, ack 0-wait -> mem_addr=0x10, mem_be=1111, mem_wdata=0xDEADBEEF, rsp_valid 2 cycles after accept, err 00.
- SB addr 0x13 data 0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x10.
- mem_rdata=0x80FF7F01, ack after 3 waits: LB @0x12 -> 0xFFFFFFFF; LBU @0x13 -> 0x00000080; LH @0x12 -> 0xFFFF80FF; LHU @0x10 -> 0x00007F01. mem_req held 4 cycles, signals stable.
- LW @0x102 -> err 01, no mem_req, rsp at N+1. funct3=011 load -> err 11. Addr 0x400 with DEPTH_BYTES=1024 -> err 10.
- Never ack, TIMEOUT=16 -> mem_req high 16 cycles then low, rsp_err=10, rdata 0. A later stray ack is ignored and the next request works.
- Assert rst_n low during ACCESS -> mem_req low immediately, no rsp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Brief    : Shared funct3 codes, response error codes, FSM states and
//             lane helpers for the load/store unit.
//  Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_BUS      = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_t;

    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W));
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // size is funct3[1:0]: 00 byte, 01 half, 10 word
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   return 4'b0001 << lane;
            2'b01:   return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_ctrl_if
//  Brief    : Core request/response and data-memory bus of the load/store unit.
//  Revision : 1.0  initial release
// ============================================================================
interface lsu_mem_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    // slave: the load/store unit itself
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    // master: execute stage plus data memory around the unit
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_load_align
//  Brief    : Combinational load extraction: selects the byte/half lane of a
//             memory word and sign- or zero-extends it per funct3.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    output logic [31:0] data
);

    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_shift = rdata >> {lane, 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = lane[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data = rdata;
        case (funct3)
            F3_B:    data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   data = {24'd0, w_byte};
            F3_H:    data = {{16{w_half[15]}}, w_half};
            F3_HU:   data = {16'd0, w_half};
            default: data = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_ctrl
//  Brief    : RV32I load/store unit: request checking, word-aligned memory
//             req/ack transaction with timeout, and load data extension.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int TIMEOUT     = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    lsu_mem_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_t   r_state;
    logic         r_we;
    logic [2:0]   r_funct3;
    logic [1:0]   r_lane;
    logic [CNT_W-1:0] r_cnt;
    logic         r_rsp_valid;
    logic [31:0]  r_rsp_rdata;
    logic [1:0]   r_rsp_err;
    logic         r_mem_req;
    logic         r_mem_we;
    logic [3:0]   r_mem_be;
    logic [31:0]  r_mem_addr;
    logic [31:0]  r_mem_wdata;

    logic         w_accept;
    logic         w_misalign;
    logic [1:0]   w_chk_err;
    logic [31:0]  w_load_data;

    assign w_accept   = bus.req_valid && (r_state == ST_IDLE);
    assign w_misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                        ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));

    // Priority: illegal encoding, then alignment, then range
    always_comb begin
        w_chk_err = ERR_OK;
        if (f3_illegal(bus.req_we, bus.req_funct3))
            w_chk_err = ERR_ILLEGAL;
        else if (w_misalign)
            w_chk_err = ERR_MISALIGN;
        else if (bus.req_addr >= 32'(DEPTH_BYTES))
            w_chk_err = ERR_BUS;
    end

    lsu_load_align u_load_align (
        .rdata  (bus.mem_rdata),
        .funct3 (r_funct3),
        .lane   (r_lane),
        .data   (w_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_funct3    <= 3'd0;
            r_lane      <= 2'd0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= ERR_OK;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we     <= bus.req_we;
                        r_funct3 <= bus.req_funct3;
                        r_lane   <= bus.req_addr[1:0];
                        if (w_chk_err != ERR_OK) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= w_chk_err;
                            r_rsp_rdata <= 32'd0;
                            r_state     <= ST_RESP;
                        end else begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= bus.req_we;
                            r_mem_be    <= byte_en(bus.req_funct3[1:0], bus.req_addr[1:0]);
                            r_mem_addr  <= {bus.req_addr[31:2], 2'b00};
                            r_mem_wdata <= store_lanes(bus.req_funct3[1:0], bus.req_wdata);
                            r_cnt       <= '0;
                            r_state     <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (bus.mem_ack) begin
                        r_mem_req   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= ERR_OK;
                        r_rsp_rdata <= r_we ? 32'd0 : w_load_data;
                        r_cnt       <= '0;
                        r_state     <= ST_RESP;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // this cycle is the TIMEOUT-th unacknowledged one
                        r_mem_req   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= ERR_BUS;
                        r_rsp_rdata <= 32'd0;
                        r_cnt       <= '0;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_mem_ctrl
//  Brief    : Self-checking bench for lsu_mem_ctrl: directed vector table,
//             timeout/reset sequences and randomized requests vs. a model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    localparam int DEPTH = 1024;
    localparam int TMO   = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_mem_ctrl_if bus();

    lsu_mem_ctrl #(.DEPTH_BYTES(DEPTH), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        bit        we;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wdata;
        int        waits;
        bit [31:0] rword;
        bit [1:0]  e_pre;
        bit [31:0] e_rdata;
        bit [3:0]  e_be;
        bit [31:0] e_wdata;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model from the instruction semantics ----------------
    function automatic bit [1:0] m_err(bit we, bit [2:0] f3, bit [31:0] addr);
        int size = f3 % 4;
        if (we ? (f3 > 2) : (f3 == 3 || f3 >= 6)) return 2'd3;
        if (addr % (32'd1 << size) != 0) return 2'd1;
        if (addr >= DEPTH) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit [3:0] m_be(bit [2:0] f3, bit [31:0] addr);
        int n = 1 << (f3 % 4);
        int v = ((1 << n) - 1) << (addr % 4);
        return v[3:0];
    endfunction

    function automatic bit [31:0] m_wdata(bit [2:0] f3, bit [31:0] wdata);
        int n = 1 << (f3 % 4);
        bit [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wdata[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic bit [31:0] m_load(bit [2:0] f3, bit [31:0] addr, bit [31:0] word);
        int n = 1 << (f3 % 4);
        bit [63:0] mask = (64'd1 << (8 * n)) - 64'd1;
        bit [63:0] v = ({32'd0, word} >> (8 * (addr % 4))) & mask;
        if (f3 < 4 && v[8*n-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // One complete request; memory side answered after 'waits' stall cycles
    task automatic run_txn(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                           input bit [31:0] wdata, input int waits, input bit [31:0] rword,
                           input bit [1:0] e_pre, input bit [31:0] e_rdata,
                           input bit [3:0] e_be, input bit [31:0] e_wdata);
        bit done;
        done = 1'b0;
        @(negedge clk);
        chk("req_ready_before", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_wdata  = $urandom;
        if (e_pre != 2'd0) begin
            chk("err_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("err_rsp_err",   {30'd0, bus.rsp_err}, {30'd0, e_pre});
            chk("err_rsp_rdata", bus.rsp_rdata, 32'd0);
            chk("err_no_mem_req", {31'd0, bus.mem_req}, 32'd0);
        end else begin
            for (int k = 0; k < TMO && !done; k++) begin
                chk("mem_req_high", {31'd0, bus.mem_req}, 32'd1);
                chk("no_early_rsp", {31'd0, bus.rsp_valid}, 32'd0);
                chk("mem_addr", bus.mem_addr, addr & 32'hFFFF_FFFC);
                chk("mem_be", {28'd0, bus.mem_be}, {28'd0, e_be});
                chk("mem_we", {31'd0, bus.mem_we}, {31'd0, we});
                if (we) chk("mem_wdata", bus.mem_wdata, e_wdata);
                if (k == waits) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rword;
                end
                @(negedge clk);
                if (k == waits) begin
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = $urandom;
                    done = 1'b1;
                end
            end
            chk("mem_req_dropped", {31'd0, bus.mem_req}, 32'd0);
            chk("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("rsp_err", {30'd0, bus.rsp_err}, done ? 32'd0 : 32'd2);
            chk("rsp_rdata", bus.rsp_rdata, (done && !we) ? e_rdata : 32'd0);
        end
        @(negedge clk);
        chk("rsp_one_cycle", {31'd0, bus.rsp_valid}, 32'd0);
        chk("req_ready_after", {31'd0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected run to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit        r_we;
        bit [2:0]  r_f3;
        bit [31:0] r_addr, r_wd, r_word;
        int        r_waits;

        bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0;
        bus.req_addr = 0; bus.req_wdata = 0; bus.mem_ack = 0; bus.mem_rdata = 0;

        //            we  f3     addr          wdata          waits rword          pre   rdata          be      wdata
        tbl[0]  = '{1'b1, F3_W,  32'h10,  32'hDEADBEEF, 0, 32'h0,        2'd0, 32'h0,        4'hF, 32'hDEADBEEF};
        tbl[1]  = '{1'b1, F3_B,  32'h13,  32'h000000A5, 0, 32'h0,        2'd0, 32'h0,        4'h8, 32'hA5A5A5A5};
        tbl[2]  = '{1'b0, F3_B,  32'h12,  32'h0,        3, 32'h80FF7F01, 2'd0, 32'hFFFFFFFF, 4'h4, 32'h0};
        tbl[3]  = '{1'b0, F3_BU, 32'h13,  32'h0,        3, 32'h80FF7F01, 2'd0, 32'h00000080, 4'h8, 32'h0};
        tbl[4]  = '{1'b0, F3_H,  32'h12,  32'h0,        3, 32'h80FF7F01, 2'd0, 32'hFFFF80FF, 4'hC, 32'h0};
        tbl[5]  = '{1'b0, F3_HU, 32'h10,  32'h0,        3, 32'h80FF7F01, 2'd0, 32'h00007F01, 4'h3, 32'h0};
        tbl[6]  = '{1'b0, F3_W,  32'h102, 32'h0,        0, 32'h0,        2'd1, 32'h0,        4'h0, 32'h0};
        tbl[7]  = '{1'b0, 3'b011,32'h10,  32'h0,        0, 32'h0,        2'd3, 32'h0,        4'h0, 32'h0};
        tbl[8]  = '{1'b0, F3_W,  32'h400, 32'h0,        0, 32'h0,        2'd2, 32'h0,        4'h0, 32'h0};
        tbl[9]  = '{1'b1, F3_H,  32'h22,  32'h1234ABCD, 1, 32'h0,        2'd0, 32'h0,        4'hC, 32'hABCDABCD};
        tbl[10] = '{1'b1, F3_BU, 32'h20,  32'h0,        0, 32'h0,        2'd3, 32'h0,        4'h0, 32'h0};
        tbl[11] = '{1'b1, F3_H,  32'h21,  32'h0,        0, 32'h0,        2'd1, 32'h0,        4'h0, 32'h0};
        tbl[12] = '{1'b0, F3_W,  32'h3FC, 32'h0,        2, 32'h12345678, 2'd0, 32'h12345678, 4'hF, 32'h0};
        tbl[13] = '{1'b0, 3'b111,32'h401, 32'h0,        0, 32'h0,        2'd3, 32'h0,        4'h0, 32'h0};
        tbl[14] = '{1'b0, F3_W,  32'h402, 32'h0,        0, 32'h0,        2'd1, 32'h0,        4'h0, 32'h0};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", {30'd0, bus.rsp_err}, 32'd0);
        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_mem_be", {28'd0, bus.mem_be}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++)
            run_txn(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].waits, tbl[i].rword,
                    tbl[i].e_pre, tbl[i].e_rdata, tbl[i].e_be, tbl[i].e_wdata);

        // memory never answers: abort after TMO cycles of mem_req
        run_txn(1'b0, F3_W, 32'h20, 32'h0, 100, 32'h0, 2'd0, 32'h0, 4'hF, 32'h0);

        // stray ack while idle must be ignored
        @(negedge clk);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("stray_ack_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        chk("stray_ack_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("stray_ack_no_req", {31'd0, bus.mem_req}, 32'd0);
        run_txn(1'b0, F3_HU, 32'h32, 32'h0, 1, 32'hBEEF1234, 2'd0, 32'h0000BEEF, 4'hC, 32'h0);

        // reset asserted during ACCESS
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = F3_W; bus.req_addr = 32'h40;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("pre_rst_mem_req", {31'd0, bus.mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_drop_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        chk("rst_hold_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rel_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_rel_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rel_no_req", {31'd0, bus.mem_req}, 32'd0);

        // randomized requests against the model
        for (int t = 0; t < 60; t++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_f3   = 3'($urandom_range(0, 7));
            r_addr = $urandom_range(0, DEPTH + 40);
            if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~((32'd1 << (r_f3 % 4)) - 32'd1);
            if ($urandom_range(0, 19) == 0) r_addr = $urandom;
            r_wd    = $urandom;
            r_word  = $urandom;
            r_waits = ($urandom_range(0, 15) == 0) ? TMO + 4 : int'($urandom_range(0, 3));
            run_txn(r_we, r_f3, r_addr, r_wd, r_waits, r_word,
                    m_err(r_we, r_f3, r_addr), m_load(r_f3, r_addr, r_word),
                    m_be(r_f3, r_addr), m_wdata(r_f3, r_wd));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
